bsg_nonsynth_dramsim3_map_pipe: RTL and testbench

BSG_NONSYNTH_DRAMSIM3_MAP_PIPE -- requirements
Module: bsg_nonsynth_dramsim3_map_pipe

---
 rtl/bsg_dramsim3_pkg.sv | 24 ++
 rtl/bsg_fifo_1r1w_small.sv | 72 +++++++
 rtl/bsg_nonsynth_dramsim3_map_pipe.sv | 190 +++++++++++++++++++
 tb/tb_bsg_nonsynth_dramsim3_map_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_dramsim3_pkg.sv
// Shared definitions for the DRAMSim3 address-mapping helpers.
//
// Contents:
//   map_mode_width_gp - bit width of the mapping-mode field
//   map_mode_e        - channel-to-global address interleaving schemes
//   safe_clog2        - $clog2 that never returns 0 (used for byte offsets)

package bsg_dramsim3_pkg;

    localparam int map_mode_width_gp = 2;

    // The fourth encoding (2'd3) is deliberately left undefined so that
    // hardware can flag a mode it does not understand.
    typedef enum logic [map_mode_width_gp-1:0] {
        e_ro_ra_bg_ba_co_ch = 2'd0,
        e_ro_ra_bg_ba_ch_co = 2'd1,
        e_ro_ch_ra_ba_bg_co = 2'd2
    } map_mode_e;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with a valid/ready enqueue side and a
// valid/yumi dequeue side. Outputs come straight from state, so there is
// no combinational path from v_i to v_o.
//
// Ports:
//   clk_i, reset_i    - clock, asynchronous active-high reset
//   v_i, data_i       - enqueue request (taken when v_i & ready_o)
//   ready_o           - FIFO not full
//   v_o, data_o       - head entry valid and its contents
//   yumi_i            - consumer takes the head (ignored while v_o is low)

module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2,
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0]        mem [els_p];
    logic [ptr_width_lp-1:0]   rd_ptr;
    logic [ptr_width_lp-1:0]   wr_ptr;
    logic [count_width_lp-1:0] count;
    logic                      enq;
    logic                      deq;

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (count != count_width_lp'(els_p));
    assign v_o     = (count != '0);
    assign data_o  = mem[rd_ptr];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Storage needs no reset; occupancy is tracked separately.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (!enq && deq) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsg_nonsynth_dramsim3_map_pipe.sv
// Maps a channel-local byte address into the global DRAMSim3 address space
// and queues the result for a downstream consumer. Also keeps per-channel
// counts of accepted legal requests and a sticky illegal-request flag.
//
// Ports:
//   clk_i, reset_i           - clock, asynchronous active-high reset
//   v_i, ready_o             - request handshake (ready_o = queue not full)
//   ch_i, mode_i             - source channel and address mapping scheme
//   write_not_read_i         - request type
//   ch_addr_i                - channel-local byte address
//   v_o, yumi_i              - mapped request handshake
//   mem_addr_o               - global address (byte-offset bits always zero)
//   write_not_read_o         - type of the head request
//   req_count_o              - saturating per-channel counts, channel 0 in LSBs
//   error_o                  - set by any illegal request until reset

module bsg_nonsynth_dramsim3_map_pipe
    import bsg_dramsim3_pkg::*;
#(
    parameter int channel_addr_width_p = 32,
    parameter int data_width_p         = 64,
    parameter int num_channels_p       = 2,
    parameter int num_columns_p        = 1024,
    parameter int num_rows_p           = 32768,
    parameter int num_ba_p             = 4,
    parameter int num_bg_p             = 4,
    parameter int num_ranks_p          = 1,
    parameter int els_p                = 2,
    parameter int count_width_p        = 16,
    parameter int debug_p              = 0,
    localparam int lg_ch_lp      = $clog2(num_channels_p),
    localparam int ch_width_lp   = (lg_ch_lp > 0) ? lg_ch_lp : 1,
    localparam int addr_width_lp = lg_ch_lp + channel_addr_width_p
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic                                    v_i,
    input  logic [ch_width_lp-1:0]                  ch_i,
    input  map_mode_e                               mode_i,
    input  logic                                    write_not_read_i,
    input  logic [channel_addr_width_p-1:0]         ch_addr_i,
    output logic                                    ready_o,
    output logic                                    v_o,
    output logic [addr_width_lp-1:0]                mem_addr_o,
    output logic                                    write_not_read_o,
    input  logic                                    yumi_i,
    output logic [num_channels_p*count_width_p-1:0] req_count_o,
    output logic                                    error_o
);

    localparam int byte_off_lp = safe_clog2(data_width_p / 8);
    localparam int lg_col_lp   = $clog2(num_columns_p);
    localparam int lg_ba_lp    = $clog2(num_ba_p);
    localparam int lg_bg_lp    = $clog2(num_bg_p);
    localparam int lg_ra_lp    = $clog2(num_ranks_p);
    localparam int lg_ro_lp    = $clog2(num_rows_p);

    // Field positions in the channel-local address (co, ba, bg, ra, ro).
    localparam int col_hi_lp = byte_off_lp + lg_col_lp;
    localparam int ba_in_lp  = col_hi_lp;
    localparam int bg_in_lp  = ba_in_lp + lg_ba_lp;
    localparam int ra_in_lp  = bg_in_lp + lg_bg_lp;
    localparam int ro_in_lp  = ra_in_lp + lg_ra_lp;

    // Field positions in the global address (co, bg, ba, ra, ch, ro).
    localparam int bg_out_lp = col_hi_lp;
    localparam int ba_out_lp = bg_out_lp + lg_bg_lp;
    localparam int ra_out_lp = ba_out_lp + lg_ba_lp;
    localparam int ch_out_lp = ra_out_lp + lg_ra_lp;
    localparam int ro_out_lp = ch_out_lp + lg_ch_lp;

    logic [addr_width_lp-1:0] addr_ext;
    logic [addr_width_lp-1:0] ch_ext;
    logic [addr_width_lp-1:0] mapped_addr;
    logic                     mode_legal;
    logic                     ch_legal;
    logic                     accept;
    logic                     legal_accept;
    logic                     fifo_v;
    logic [num_channels_p-1:0][count_width_p-1:0] counts;
    logic                     error_r;

    // A zero-width field yields an all-zero mask, so absent fields vanish.
    function automatic logic [addr_width_lp-1:0] field_mask(input int w);
        logic [addr_width_lp-1:0] m;
        m = '0;
        for (int i = 0; i < addr_width_lp; i++) begin
            if (i < w) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    assign addr_ext = addr_width_lp'(ch_addr_i);
    assign ch_ext   = addr_width_lp'(ch_i) & field_mask(lg_ch_lp);
    assign ch_legal = (int'(ch_i) < num_channels_p);

    // Low byte-offset bits are dropped by shifting down before shifting
    // fields into place, so they always come out zero.
    always_comb begin
        logic [addr_width_lp-1:0] co, ba, bg, ra, ro;
        mapped_addr = '0;
        mode_legal  = 1'b1;
        co = (addr_ext >> byte_off_lp) & field_mask(lg_col_lp);
        ba = (addr_ext >> ba_in_lp) & field_mask(lg_ba_lp);
        bg = (addr_ext >> bg_in_lp) & field_mask(lg_bg_lp);
        ra = (addr_ext >> ra_in_lp) & field_mask(lg_ra_lp);
        ro = (addr_ext >> ro_in_lp) & field_mask(lg_ro_lp);
        case (mode_i)
            e_ro_ra_bg_ba_co_ch: begin
                mapped_addr = ((addr_ext >> byte_off_lp) << (byte_off_lp + lg_ch_lp))
                            | (ch_ext << byte_off_lp);
            end
            e_ro_ra_bg_ba_ch_co: begin
                mapped_addr = ((addr_ext >> col_hi_lp) << (col_hi_lp + lg_ch_lp))
                            | (ch_ext << col_hi_lp)
                            | (co << byte_off_lp);
            end
            e_ro_ch_ra_ba_bg_co: begin
                mapped_addr = (co << byte_off_lp)
                            | (bg << bg_out_lp)
                            | (ba << ba_out_lp)
                            | (ra << ra_out_lp)
                            | (ch_ext << ch_out_lp)
                            | (ro << ro_out_lp);
            end
            default: begin
                mode_legal = 1'b0;
            end
        endcase
    end

    // Illegal requests still complete the handshake but never enter the queue.
    assign accept       = v_i & ready_o;
    assign legal_accept = accept & ch_legal & mode_legal;

    bsg_fifo_1r1w_small #(
        .width_p (addr_width_lp + 1),
        .els_p   (els_p)
    ) buffer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (legal_accept),
        .data_i  ({write_not_read_i, mapped_addr}),
        .ready_o (ready_o),
        .v_o     (fifo_v),
        .data_o  ({write_not_read_o, mem_addr_o}),
        .yumi_i  (yumi_i & fifo_v)
    );

    assign v_o = fifo_v;

    // Counters hold at all-ones rather than wrapping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            counts <= '0;
        end else if (legal_accept) begin
            for (int c = 0; c < num_channels_p; c++) begin
                if ((ch_i == ch_width_lp'(c)) && (counts[c] != '1)) begin
                    counts[c] <= counts[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_r <= 1'b0;
        end else if (accept && !(ch_legal && mode_legal)) begin
            error_r <= 1'b1;
        end
    end

    assign req_count_o = counts;
    assign error_o     = error_r;

    if (debug_p != 0) begin : g_debug
        yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
            else $error("yumi_i asserted while v_o is low");

        always @(posedge clk_i) begin
            if (!reset_i && accept) begin
                $info("accept ch=%0d mode=%0d wnr=%0b ch_addr=%h mem_addr=%h legal=%0b",
                      ch_i, mode_i, write_not_read_i, ch_addr_i, mapped_addr, ch_legal && mode_legal);
            end
        end
    end

endmodule

// File: tb/tb_bsg_nonsynth_dramsim3_map_pipe.sv
// Testbench for bsg_nonsynth_dramsim3_map_pipe using the reference geometry
// (64-bit data, 1024 columns, 4 banks, 4 bank groups, 1 rank, 32768 rows,
// 2 channels, 32-bit channel address). Expected beats go into a scoreboard
// queue when a legal request is accepted and are compared when consumed.

module tb_bsg_nonsynth_dramsim3_map_pipe;
    import bsg_dramsim3_pkg::*;

    localparam int cw_lp = 4;

    logic        clk;
    logic        reset_i;
    logic        v_i;
    logic [0:0]  ch_i;
    map_mode_e   mode_i;
    logic        write_not_read_i;
    logic [31:0] ch_addr_i;
    logic        ready_o;
    logic        v_o;
    logic [32:0] mem_addr_o;
    logic        write_not_read_o;
    logic        yumi_i;
    logic [7:0]  req_count_o;
    logic        error_o;

    typedef struct packed {
        logic        ch;
        map_mode_e   mode;
        logic        wnr;
        logic [31:0] addr;
        logic [32:0] exp_addr;
        logic        legal;
    } vec_t;

    typedef struct packed {
        logic [32:0] addr;
        logic        wnr;
    } sb_t;

    vec_t        vecs [6];
    sb_t         sb_q [$];
    logic [3:0]  cnt [2];
    logic        drv_legal;
    logic [32:0] drv_exp_addr;
    int          checks;
    int          errors;

    bsg_nonsynth_dramsim3_map_pipe #(
        .channel_addr_width_p (32),
        .data_width_p         (64),
        .num_channels_p       (2),
        .num_columns_p        (1024),
        .num_rows_p           (32768),
        .num_ba_p             (4),
        .num_bg_p             (4),
        .num_ranks_p          (1),
        .els_p                (2),
        .count_width_p        (cw_lp),
        .debug_p              (0)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .ch_i             (ch_i),
        .mode_i           (mode_i),
        .write_not_read_i (write_not_read_i),
        .ch_addr_i        (ch_addr_i),
        .ready_o          (ready_o),
        .v_o              (v_o),
        .mem_addr_o       (mem_addr_o),
        .write_not_read_o (write_not_read_o),
        .yumi_i           (yumi_i),
        .req_count_o      (req_count_o),
        .error_o          (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic ch, input map_mode_e mode, input logic wnr,
                                   input logic [31:0] addr, input logic [32:0] exp_addr, input logic legal);
        vec_t v;
        v.ch = ch; v.mode = mode; v.wnr = wnr; v.addr = addr; v.exp_addr = exp_addr; v.legal = legal;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        v_i              = 1'b1;
        ch_i             = v.ch;
        mode_i           = v.mode;
        write_not_read_i = v.wnr;
        ch_addr_i        = v.addr;
        drv_legal        = v.legal;
        drv_exp_addr     = v.exp_addr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] modelCount();
        return 64'({cnt[1], cnt[0]});
    endfunction

    // Scoreboard: compare the head beat when it is consumed, then record any
    // legal request that the next edge will accept.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (v_o && yumi_i) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat actual=%h expected=none", mem_addr_o);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    checkOutput("beat_addr", 64'(mem_addr_o), 64'(e.addr));
                    checkOutput("beat_wnr", 64'(write_not_read_o), 64'(e.wnr));
                end
            end
            if (v_i && ready_o && drv_legal) begin
                sb_q.push_back('{addr: drv_exp_addr, wnr: write_not_read_i});
                if (cnt[ch_i] != 4'hF) cnt[ch_i] = cnt[ch_i] + 4'd1;
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        cnt[0] = '0; cnt[1] = '0;
        reset_i = 1'b1; v_i = 1'b0; ch_i = '0; mode_i = e_ro_ra_bg_ba_co_ch;
        write_not_read_i = 1'b0; ch_addr_i = '0; yumi_i = 1'b0;
        drv_legal = 1'b0; drv_exp_addr = '0;

        vecs[0] = mkVec(1'b1, e_ro_ra_bg_ba_co_ch, 1'b0, 32'h0000_0048, 33'h0_0000_0098, 1'b1);
        vecs[1] = mkVec(1'b1, e_ro_ra_bg_ba_ch_co, 1'b0, 32'h0000_2008, 33'h0_0000_6008, 1'b1);
        vecs[2] = mkVec(1'b0, e_ro_ch_ra_ba_bg_co, 1'b0, 32'h0003_2000, 33'h0_0004_C000, 1'b1);
        vecs[3] = mkVec(1'b0, e_ro_ra_bg_ba_co_ch, 1'b1, 32'hFFFF_FFF8, 33'h1_FFFF_FFF0, 1'b1);
        vecs[4] = mkVec(1'b0, e_ro_ra_bg_ba_ch_co, 1'b1, 32'h1234_5678, 33'h0_2468_9678, 1'b1);
        vecs[5] = mkVec(1'b1, e_ro_ch_ra_ba_bg_co, 1'b1, 32'hFFFF_FFFF, 33'h1_FFFF_FFF8, 1'b1);

        #3;
        checkOutput("reset_v_o", 64'(v_o), 64'd0);
        checkOutput("reset_ready_o", 64'(ready_o), 64'd1);
        checkOutput("reset_req_count", 64'(req_count_o), 64'd0);
        checkOutput("reset_error_o", 64'(error_o), 64'd0);
        tick(); tick();
        reset_i = 1'b0;

        // Mapping table with a consumer that always takes the head.
        yumi_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            applyStimulus(vecs[i]);
            tick();
            v_i = 1'b0;
            @(negedge clk);
            checkOutput("table_v_o", 64'(v_o), 64'(vecs[i].legal));
            checkOutput("table_req_count", 64'(req_count_o), modelCount());
        end
        checkOutput("ch0_count_after_table", 64'(req_count_o[3:0]), 64'd3);
        tick();

        // Backpressure: two accepts fill the buffer, third waits for a drain.
        yumi_i = 1'b0;
        applyStimulus(mkVec(1'b0, e_ro_ra_bg_ba_co_ch, 1'b0, 32'h100, 33'h200, 1'b1));
        @(negedge clk);
        checkOutput("bp_ready_empty", 64'(ready_o), 64'd1);
        tick();
        applyStimulus(mkVec(1'b0, e_ro_ra_bg_ba_co_ch, 1'b1, 32'h108, 33'h210, 1'b1));
        @(negedge clk);
        checkOutput("bp_ready_one", 64'(ready_o), 64'd1);
        tick();
        applyStimulus(mkVec(1'b0, e_ro_ra_bg_ba_co_ch, 1'b0, 32'h110, 33'h220, 1'b1));
        @(negedge clk);
        checkOutput("bp_ready_full", 64'(ready_o), 64'd0);
        checkOutput("bp_v_o_full", 64'(v_o), 64'd1);
        tick();
        yumi_i = 1'b1;
        @(negedge clk);
        checkOutput("bp_ready_full_yumi", 64'(ready_o), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("bp_ready_after_drain", 64'(ready_o), 64'd1);
        tick();
        v_i = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("bp_v_o_drained", 64'(v_o), 64'd0);
        checkOutput("bp_sb_empty", 64'(sb_q.size()), 64'd0);
        checkOutput("bp_req_count", 64'(req_count_o), modelCount());

        // Undefined mapping mode: accepted, flagged, never enqueued.
        checkOutput("err_before", 64'(error_o), 64'd0);
        tick();
        applyStimulus(mkVec(1'b1, map_mode_e'(2'd3), 1'b0, 32'h40, 33'h0, 1'b0));
        @(negedge clk);
        checkOutput("err_ready", 64'(ready_o), 64'd1);
        tick();
        v_i = 1'b0;
        @(negedge clk);
        checkOutput("err_set", 64'(error_o), 64'd1);
        checkOutput("err_v_o", 64'(v_o), 64'd0);
        checkOutput("err_req_count", 64'(req_count_o), modelCount());
        tick();
        @(negedge clk);
        checkOutput("err_sticky", 64'(error_o), 64'd1);

        // Streaming with simultaneous enqueue/dequeue drives ch0 to saturation.
        tick();
        for (int k = 0; k < 14; k++) begin
            applyStimulus(mkVec(1'b0, e_ro_ra_bg_ba_co_ch, k[0], 32'(k) * 32'd8, 33'(k) << 4, 1'b1));
            tick();
        end
        v_i = 1'b0;
        @(negedge clk);
        checkOutput("sat_ch0", 64'(req_count_o[3:0]), 64'hF);
        checkOutput("sat_req_count", 64'(req_count_o), modelCount());
        tick();

        // Reset with two beats buffered discards them.
        yumi_i = 1'b0;
        applyStimulus(mkVec(1'b1, e_ro_ra_bg_ba_co_ch, 1'b0, 32'h10, 33'h28, 1'b1));
        tick();
        applyStimulus(mkVec(1'b1, e_ro_ra_bg_ba_co_ch, 1'b1, 32'h18, 33'h38, 1'b1));
        tick();
        v_i = 1'b0;
        @(negedge clk);
        checkOutput("rst_buffered_ready", 64'(ready_o), 64'd0);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("rst_v_o", 64'(v_o), 64'd0);
        checkOutput("rst_ready_o", 64'(ready_o), 64'd1);
        checkOutput("rst_req_count", 64'(req_count_o), 64'd0);
        checkOutput("rst_error_o", 64'(error_o), 64'd0);
        sb_q.delete();
        cnt[0] = '0; cnt[1] = '0;
        tick(); tick();
        reset_i = 1'b0;
        yumi_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("post_rst_v_o", 64'(v_o), 64'd0);
        end

        // One fresh request after reset goes through normally.
        tick();
        applyStimulus(vecs[0]);
        tick();
        v_i = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_beat", 64'(v_o), 64'd1);
        checkOutput("post_rst_count", 64'(req_count_o), 64'h10);
        tick();
        @(negedge clk);
        checkOutput("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
